// File: rtl/iopad_array_pkg.sv
// Shared configuration-bit layout and per-pad config type for the I/O pad array tile.
package iopad_array_pkg;

    localparam int unsigned CFG_DIR     = 0;
    localparam int unsigned CFG_INV_OUT = 1;
    localparam int unsigned CFG_INV_IN  = 2;
    localparam int unsigned CFG_BITS    = 3;

    // Packed so that bit b of the struct matches config bit b of the pad.
    typedef struct packed {
        logic inv_in;
        logic inv_out;
        logic dir;
    } pad_cfg_t;

    function automatic pad_cfg_t pad_cfg(input logic [CFG_BITS-1:0] bits);
        pad_cfg_t c;
        c.dir     = bits[CFG_DIR];
        c.inv_out = bits[CFG_INV_OUT];
        c.inv_in  = bits[CFG_INV_IN];
        return c;
    endfunction

endpackage

// File: rtl/GPIO.sv
// Bidirectional GPIO cell: drives PAD from A when DIR=1, otherwise high-Z; Y always follows PAD.
module GPIO (
    input  logic A,
    output logic Y,
    inout  logic PAD,
    input  logic DIR
);

    assign PAD = DIR ? A : 1'bz;
    assign Y   = PAD;

endmodule

// File: rtl/iopad_cfg_chain.sv
// Pad-array configuration chain with load-progress counter.
// IOPAD_ARRAY_SHADOW_CFG_EN adds a commit-loaded shadow copy that drives the pads instead of the chain.
module iopad_cfg_chain
    import iopad_array_pkg::*;
#(
    parameter int unsigned NUM_PADS = 4
) (
    input  logic                         prog_clk,
    input  logic                         pReset,
    input  logic                         ccff_head,
    input  logic                         ccff_en,
    input  logic                         ccff_commit,
    output logic                         ccff_tail,
    output logic                         ccff_done,
    output logic [NUM_PADS*CFG_BITS-1:0] cfg
);

    localparam int unsigned CHAIN_LEN = NUM_PADS * CFG_BITS;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] chain;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 done;

    // A commit restarts the count; a shift in the same cycle is its first bit.
    always_comb begin
        bit_cnt_next = bit_cnt;
        if (ccff_commit) begin
            bit_cnt_next = ccff_en ? CNT_W'(1) : '0;
        end else if (ccff_en && (bit_cnt != CNT_FULL)) begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            chain   <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (ccff_en) begin
                chain <= {chain[CHAIN_LEN-2:0], ccff_head};
            end
            bit_cnt <= bit_cnt_next;
            done    <= (bit_cnt_next == CNT_FULL);
        end
    end

    assign ccff_tail = chain[CHAIN_LEN-1];
    assign ccff_done = done;

`ifdef IOPAD_ARRAY_SHADOW_CFG_EN
    logic [CHAIN_LEN-1:0] shadow;

    // Captures the pre-shift chain even when a shift shares the commit cycle.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shadow <= '0;
        end else if (ccff_commit) begin
            shadow <= chain;
        end
    end

    assign cfg = shadow;
`else
    assign cfg = chain;
`endif

endmodule

// File: rtl/logical_tile_io_mode_physical__iopad_array.sv
// Multi-pad I/O logical tile: NUM_PADS GPIO cells configured from one shared chain segment.
// Build with IOPAD_ARRAY_SHADOW_CFG_EN to hold pad configuration until ccff_commit.
module logical_tile_io_mode_physical__iopad_array #(
    parameter int unsigned NUM_PADS = 4,
    parameter int unsigned CFG_BITS = 3
) (
    input  logic                prog_clk,
    input  logic                pReset,
    inout  logic [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_PADS-1:0] iopad_outpad,
    output logic [NUM_PADS-1:0] iopad_inpad,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                ccff_commit,
    output logic                ccff_tail,
    output logic                ccff_done
);

    import iopad_array_pkg::pad_cfg_t;
    import iopad_array_pkg::pad_cfg;

    localparam int unsigned CHAIN_LEN = NUM_PADS * CFG_BITS;

    logic [CHAIN_LEN-1:0] eff_cfg;
    logic [NUM_PADS-1:0]  gpio_a;
    logic [NUM_PADS-1:0]  gpio_y;

    iopad_cfg_chain #(
        .NUM_PADS(NUM_PADS)
    ) u_cfg_chain (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .ccff_head  (ccff_head),
        .ccff_en    (ccff_en),
        .ccff_commit(ccff_commit),
        .ccff_tail  (ccff_tail),
        .ccff_done  (ccff_done),
        .cfg        (eff_cfg)
    );

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        pad_cfg_t pcfg;

        assign pcfg      = pad_cfg(eff_cfg[p*CFG_BITS +: CFG_BITS]);
        assign gpio_a[p] = iopad_outpad[p] ^ pcfg.inv_out;

        GPIO u_gpio (
            .A  (gpio_a[p]),
            .Y  (gpio_y[p]),
            .PAD(gfpga_pad_GPIO_PAD[p]),
            .DIR(pcfg.dir)
        );

        assign iopad_inpad[p] = gpio_y[p] ^ pcfg.inv_in;
    end

endmodule

// File: tb/tb_logical_tile_io_mode_physical__iopad_array.sv
// Directed self-checking bench for the pad array tile with NUM_PADS=2 (six-bit chain).
module tb_logical_tile_io_mode_physical__iopad_array;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       ccff_head;
    logic       ccff_en;
    logic       ccff_commit;
    logic [1:0] iopad_outpad;
    logic [1:0] iopad_inpad;
    logic       ccff_tail;
    logic       ccff_done;
    wire  [1:0] pad;
    logic [1:0] ext_en;
    logic [1:0] ext_val;

    int checks = 0;
    int errors = 0;

    assign pad[0] = ext_en[0] ? ext_val[0] : 1'bz;
    assign pad[1] = ext_en[1] ? ext_val[1] : 1'bz;

    logical_tile_io_mode_physical__iopad_array #(
        .NUM_PADS(2)
    ) dut (
        .prog_clk          (prog_clk),
        .pReset            (pReset),
        .gfpga_pad_GPIO_PAD(pad),
        .iopad_outpad      (iopad_outpad),
        .iopad_inpad       (iopad_inpad),
        .ccff_head         (ccff_head),
        .ccff_en           (ccff_en),
        .ccff_commit       (ccff_commit),
        .ccff_tail         (ccff_tail),
        .ccff_done         (ccff_done)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic shift_bit(input logic b);
        @(negedge prog_clk);
        ccff_head = b;
        ccff_en   = 1'b1;
        @(posedge prog_clk);
        #1;
        ccff_en = 1'b0;
    endtask

    task automatic load_word(input logic [5:0] w);
        for (int i = 5; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic do_commit(input logic with_en, input logic b);
        @(negedge prog_clk);
        ccff_commit = 1'b1;
        ccff_en     = with_en;
        ccff_head   = b;
        @(posedge prog_clk);
        #1;
        ccff_commit = 1'b0;
        ccff_en     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge prog_clk);
        pReset = 1'b1;
        #2;
        pReset = 1'b0;
        @(posedge prog_clk);
        #1;
    endtask

    // Pads only see a freshly loaded word after a commit in the shadow build.
    task automatic apply_cfg();
`ifdef IOPAD_ARRAY_SHADOW_CFG_EN
        do_commit(1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset();
        logic exp_done;
        #1;
        checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b expected 0", ccff_tail); end
        checks++; if (ccff_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ccff_done); end
        ext_en = 2'b11; ext_val = 2'b01; iopad_outpad = 2'b11; #1;
        checks++; if (iopad_inpad !== 2'b01) begin errors++; $display("FAIL reset_pad_z_01: got %b expected 01", iopad_inpad); end
        ext_val = 2'b10; #1;
        checks++; if (iopad_inpad !== 2'b10) begin errors++; $display("FAIL reset_pad_z_10: got %b expected 10", iopad_inpad); end
        ext_en = 2'b00;
        @(negedge prog_clk);
        pReset = 1'b0;
        for (int k = 0; k < 6; k++) shift_bit(1'b1);
        checks++; if (ccff_done !== 1'b1) begin errors++; $display("FAIL preload_done: got %b expected 1", ccff_done); end
        checks++; if (ccff_tail !== 1'b1) begin errors++; $display("FAIL preload_tail: got %b expected 1", ccff_tail); end
        ccff_head = 1'b1; ccff_en = 1'b1; #1;
        pReset = 1'b1; #1;
        checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL midreset_tail: got %b expected 0", ccff_tail); end
        checks++; if (ccff_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", ccff_done); end
        ext_en = 2'b11; ext_val = 2'b10; #1;
        checks++; if (iopad_inpad !== 2'b10) begin errors++; $display("FAIL midreset_pad_z: got %b expected 10", iopad_inpad); end
        ext_en = 2'b00; ccff_en = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            shift_bit(1'b0);
            exp_done = (k == 6);
            checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL flush_tail[%0d]: got %b expected 0", k, ccff_tail); end
            checks++; if (ccff_done !== exp_done) begin errors++; $display("FAIL flush_done[%0d]: got %b expected %b", k, ccff_done, exp_done); end
        end
    endtask

    task automatic test_load();
        logic [5:0] w;
        logic       exp_done;
        w = 6'b101001;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            shift_bit(w[i]);
            exp_done = (i == 0);
            checks++; if (ccff_done !== exp_done) begin errors++; $display("FAIL load_done[%0d]: got %b expected %b", 6 - i, ccff_done, exp_done); end
        end
        checks++; if (ccff_tail !== 1'b1) begin errors++; $display("FAIL load_tail: got %b expected 1", ccff_tail); end
        apply_cfg();
        iopad_outpad = 2'b10; #1;
        checks++; if (pad !== 2'b10) begin errors++; $display("FAIL load_pad_10: got %b expected 10", pad); end
        checks++; if (iopad_inpad !== 2'b00) begin errors++; $display("FAIL load_inpad_10: got %b expected 00", iopad_inpad); end
        iopad_outpad = 2'b01; #1;
        checks++; if (pad !== 2'b01) begin errors++; $display("FAIL load_pad_01: got %b expected 01", pad); end
        checks++; if (iopad_inpad !== 2'b11) begin errors++; $display("FAIL load_inpad_01: got %b expected 11", iopad_inpad); end
    endtask

    task automatic test_input_mode();
        load_word(6'b000000);
        apply_cfg();
        checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL input_tail: got %b expected 0", ccff_tail); end
        iopad_outpad = 2'b11; ext_en = 2'b11; ext_val = 2'b01; #1;
        checks++; if (iopad_inpad !== 2'b01) begin errors++; $display("FAIL input_inpad_01: got %b expected 01", iopad_inpad); end
        ext_val = 2'b10; #1;
        checks++; if (iopad_inpad !== 2'b10) begin errors++; $display("FAIL input_inpad_10: got %b expected 10", iopad_inpad); end
        ext_en = 2'b00;
    endtask

    task automatic test_inversion();
        load_word(6'b000100);
        apply_cfg();
        ext_en = 2'b11; ext_val = 2'b01; #1;
        checks++; if (iopad_inpad !== 2'b00) begin errors++; $display("FAIL invin_01: got %b expected 00", iopad_inpad); end
        ext_val = 2'b00; #1;
        checks++; if (iopad_inpad !== 2'b01) begin errors++; $display("FAIL invin_00: got %b expected 01", iopad_inpad); end
        ext_val = 2'b10; #1;
        checks++; if (iopad_inpad !== 2'b11) begin errors++; $display("FAIL invin_10: got %b expected 11", iopad_inpad); end
        ext_en = 2'b00;
        load_word(6'b011011);
        apply_cfg();
        iopad_outpad = 2'b01; #1;
        checks++; if (pad !== 2'b10) begin errors++; $display("FAIL invout_pad_01: got %b expected 10", pad); end
        checks++; if (iopad_inpad !== 2'b10) begin errors++; $display("FAIL invout_inpad_01: got %b expected 10", iopad_inpad); end
        iopad_outpad = 2'b10; #1;
        checks++; if (pad !== 2'b01) begin errors++; $display("FAIL invout_pad_10: got %b expected 01", pad); end
    endtask

    task automatic test_pass_through();
        logic [11:0] s;
        logic        exp_tail;
        logic        exp_done;
        s = 12'b110010_011101;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            shift_bit(s[12 - k]);
            exp_tail = 1'b0;
            if (k >= 6) exp_tail = s[17 - k];
            exp_done = (k >= 6);
            checks++; if (ccff_tail !== exp_tail) begin errors++; $display("FAIL pass_tail[%0d]: got %b expected %b", k, ccff_tail, exp_tail); end
            checks++; if (ccff_done !== exp_done) begin errors++; $display("FAIL pass_done[%0d]: got %b expected %b", k, ccff_done, exp_done); end
        end
    endtask

    task automatic test_commit_count();
        logic exp_done;
        do_commit(1'b0, 1'b0);
        checks++; if (ccff_done !== 1'b0) begin errors++; $display("FAIL commit_done: got %b expected 0", ccff_done); end
        for (int k = 1; k <= 6; k++) begin
            shift_bit(1'b0);
            exp_done = (k == 6);
            checks++; if (ccff_done !== exp_done) begin errors++; $display("FAIL recount_done[%0d]: got %b expected %b", k, ccff_done, exp_done); end
        end
        do_commit(1'b1, 1'b0);
        checks++; if (ccff_done !== 1'b0) begin errors++; $display("FAIL commit_en_done: got %b expected 0", ccff_done); end
        for (int k = 1; k <= 5; k++) begin
            shift_bit(1'b0);
            exp_done = (k == 5);
            checks++; if (ccff_done !== exp_done) begin errors++; $display("FAIL commit_en_count[%0d]: got %b expected %b", k, ccff_done, exp_done); end
        end
    endtask

    task automatic test_commit_with_shift();
        load_word(6'b011011);
        do_commit(1'b1, 1'b0);
        checks++; if (ccff_tail !== 1'b1) begin errors++; $display("FAIL cws_tail: got %b expected 1", ccff_tail); end
`ifdef IOPAD_ARRAY_SHADOW_CFG_EN
        iopad_outpad = 2'b00; #1;
        checks++; if (pad !== 2'b11) begin errors++; $display("FAIL cws_shadow_pad: got %b expected 11", pad); end
        checks++; if (iopad_inpad !== 2'b11) begin errors++; $display("FAIL cws_shadow_inpad: got %b expected 11", iopad_inpad); end
`else
        ext_en = 2'b11; ext_val = 2'b01; #1;
        checks++; if (iopad_inpad !== 2'b10) begin errors++; $display("FAIL cws_chain_inpad: got %b expected 10", iopad_inpad); end
        ext_en = 2'b00;
`endif
    endtask

`ifdef IOPAD_ARRAY_SHADOW_CFG_EN
    task automatic test_shadow_hold();
        do_reset();
        load_word(6'b101001);
        iopad_outpad = 2'b10; ext_en = 2'b11; ext_val = 2'b00; #1;
        checks++; if (iopad_inpad !== 2'b00) begin errors++; $display("FAIL hold_inpad_00: got %b expected 00", iopad_inpad); end
        ext_val = 2'b11; #1;
        checks++; if (iopad_inpad !== 2'b11) begin errors++; $display("FAIL hold_inpad_11: got %b expected 11", iopad_inpad); end
        ext_en = 2'b00;
        do_commit(1'b0, 1'b0);
        checks++; if (ccff_done !== 1'b0) begin errors++; $display("FAIL hold_commit_done: got %b expected 0", ccff_done); end
        checks++; if (pad !== 2'b10) begin errors++; $display("FAIL hold_commit_pad: got %b expected 10", pad); end
        checks++; if (iopad_inpad !== 2'b00) begin errors++; $display("FAIL hold_commit_inpad: got %b expected 00", iopad_inpad); end
    endtask
`endif

    initial begin
        pReset       = 1'b1;
        ccff_head    = 1'b0;
        ccff_en      = 1'b0;
        ccff_commit  = 1'b0;
        iopad_outpad = 2'b00;
        ext_en       = 2'b00;
        ext_val      = 2'b00;
        test_reset();
        test_load();
        test_input_mode();
        test_inversion();
        test_pass_through();
        test_commit_count();
        test_commit_with_shift();
`ifdef IOPAD_ARRAY_SHADOW_CFG_EN
        test_shadow_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
